// File: rtl/trace_line_emitter_if.sv
// Character-in / byte-out stream bundle for the trace line emitter.
// master drives characters and accepts bytes; slave is the emitter.
interface trace_line_emitter_if;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_char;
    logic       in_last;
    logic       cycle_inc;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_char;
    logic       overflow;
    logic       busy;

    modport master (
        output in_val, in_char, in_last, cycle_inc, out_rdy,
        input  in_rdy, out_val, out_char, overflow, busy
    );

    modport slave (
        input  in_val, in_char, in_last, cycle_inc, out_rdy,
        output in_rdy, out_val, out_char, overflow, busy
    );
endinterface

// File: rtl/trace_line_emitter.sv
// Buffers one trace line, then emits it as "%4d: <line>\n" bytes, where the
// number is an internal BCD cycle count advanced by cycle_inc pulses.
module trace_line_emitter #(
    parameter int unsigned NCHARS     = 64,
    parameter int unsigned CYC_DIGITS = 4
) (
    input logic                  clk,
    input logic                  reset,
    trace_line_emitter_if.slave  bus
);
    localparam int unsigned AW = $clog2(NCHARS);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned VW = 4 * CYC_DIGITS;
    localparam int unsigned DW = $clog2(CYC_DIGITS + 2);

    typedef enum logic [1:0] {FILL, PREFIX, BODY, NL} state_t;

    state_t        state;
    logic          in_rdy_r;
    logic          out_val_r;
    logic [7:0]    out_char_r;
    logic          overflow_r;
    logic          busy_r;
    logic [VW-1:0] bcd;
    logic [VW-1:0] snap;
    logic [CW-1:0] count;
    logic [CW-1:0] rd;
    logic [DW-1:0] dig;
    logic [7:0]    line_buf [NCHARS];

    logic in_xfer;
    logic out_xfer;
    logic wr_en;

    assign in_xfer  = bus.in_val && in_rdy_r;
    assign out_xfer = out_val_r && bus.out_rdy;
    assign wr_en    = (state == FILL) && in_xfer && (bus.in_char != 8'h00)
                      && (count < CW'(NCHARS));

    assign bus.in_rdy   = in_rdy_r;
    assign bus.out_val  = out_val_r;
    assign bus.out_char = out_char_r;
    assign bus.overflow = overflow_r;
    assign bus.busy     = busy_r;

    function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < CYC_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Byte idx of the prefix: digits MSB first with leading zeros blanked
    // (last digit always shown), then ':' and a trailing space.
    function automatic logic [7:0] prefix_byte(input logic [VW-1:0] v,
                                               input logic [DW-1:0] idx);
        logic [7:0] b;
        logic       lead;
        logic [3:0] d;
        b    = 8'h20;
        lead = 1'b1;
        for (int unsigned i = 0; i < CYC_DIGITS; i++) begin
            d = v[4*(CYC_DIGITS-1-i) +: 4];
            if ((d != 4'd0) || (i == CYC_DIGITS - 1)) lead = 1'b0;
            if (DW'(i) == idx) b = lead ? 8'h20 : {4'h3, d};
        end
        if (idx == DW'(CYC_DIGITS)) b = 8'h3A;
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) line_buf[count[AW-1:0]] <= bus.in_char;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            in_rdy_r   <= 1'b0;
            out_val_r  <= 1'b0;
            out_char_r <= 8'h00;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            bcd        <= '0;
            snap       <= '0;
            count      <= '0;
            rd         <= '0;
            dig        <= '0;
        end else begin
            if (bus.cycle_inc) bcd <= bcd_inc(bcd);

            case (state)
                FILL: begin
                    in_rdy_r <= 1'b1;
                    if (in_xfer) begin
                        if (bus.in_char != 8'h00) begin
                            if (count < CW'(NCHARS)) count <= count + 1'b1;
                            else                     overflow_r <= 1'b1;
                        end
                        // The first prefix byte is loaded here so out_val rises
                        // the very next cycle; it is formed from the pre-increment count.
                        if (bus.in_last) begin
                            snap       <= bcd;
                            in_rdy_r   <= 1'b0;
                            busy_r     <= 1'b1;
                            out_val_r  <= 1'b1;
                            out_char_r <= prefix_byte(bcd, '0);
                            dig        <= '0;
                            state      <= PREFIX;
                        end
                    end
                end

                PREFIX: begin
                    if (out_xfer) begin
                        if (dig == DW'(CYC_DIGITS + 1)) begin
                            if (count == '0) begin
                                out_char_r <= 8'h0A;
                                state      <= NL;
                            end else begin
                                out_char_r <= line_buf[0];
                                rd         <= CW'(1);
                                state      <= BODY;
                            end
                        end else begin
                            dig        <= dig + 1'b1;
                            out_char_r <= prefix_byte(snap, dig + 1'b1);
                        end
                    end
                end

                BODY: begin
                    if (out_xfer) begin
                        if (rd == count) begin
                            out_char_r <= 8'h0A;
                            state      <= NL;
                        end else begin
                            out_char_r <= line_buf[rd[AW-1:0]];
                            rd         <= rd + 1'b1;
                        end
                    end
                end

                NL: begin
                    if (out_xfer) begin
                        count     <= '0;
                        busy_r    <= 1'b0;
                        out_val_r <= 1'b0;
                        in_rdy_r  <= 1'b1;
                        state     <= FILL;
                    end
                end

                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_trace_line_emitter.sv
// Scoreboard bench for trace_line_emitter: expected lines are queued as they
// are issued, and a negedge monitor pops and compares every accepted byte.
module tb_trace_line_emitter;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    trace_line_emitter_if bus ();

    trace_line_emitter #(.NCHARS(4), .CYC_DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    bit         rand_rdy = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_char = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every byte accepted by the sink is checked against the queue head.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) check("hold_stable", bus.out_char, stall_char);
            if (bus.out_val && bus.out_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_byte: got %0h expected none at %0t", bus.out_char, $time);
                end else begin
                    check("byte", bus.out_char, exp_q.pop_front());
                end
            end
            stall_prev <= bus.out_val && !bus.out_rdy;
            stall_char <= bus.out_char;
        end
    end

    always @(posedge clk) begin
        #1;
        bus.out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic send(input logic [7:0] c, input logic last, input logic inc);
        int unsigned t = 0;
        bus.in_val    = 1'b1;
        bus.in_char   = c;
        bus.in_last   = last;
        bus.cycle_inc = inc;
        @(negedge clk);
        while (!bus.in_rdy && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!bus.in_rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_rdy=0 expected 1 for char %0h", c);
        end
        @(posedge clk);
        #1;
        bus.in_val    = 1'b0;
        bus.in_last   = 1'b0;
        bus.cycle_inc = 1'b0;
        bus.in_char   = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], (i == s.len() - 1), 1'b0);
    endtask

    task automatic pulses(input int n);
        if (n > 0) begin
            bus.cycle_inc = 1'b1;
            repeat (n) @(posedge clk);
            #1;
            bus.cycle_inc = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        @(negedge clk);
        while ((bus.busy || exp_q.size() != 0) && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (bus.busy || exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d expected 0/0", bus.busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_val    = 1'b0;
        bus.in_char   = 8'h00;
        bus.in_last   = 1'b0;
        bus.cycle_inc = 1'b0;
        bus.out_rdy   = 1'b1;

        #2;
        check("rst_in_rdy",   bus.in_rdy,   0);
        check("rst_out_val",  bus.out_val,  0);
        check("rst_out_char", bus.out_char, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_busy",     bus.busy,     0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Count 3, line "ab", sink always ready: nine bytes back to back.
        pulses(3);
        push_str("   3: ab\n");
        send("a", 1'b0, 1'b0);
        send("b", 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("no_bubble", bus.out_val, 1);
        end
        @(negedge clk);
        check("busy_fall",   bus.busy,    0);
        check("in_rdy_back", bus.in_rdy,  1);
        check("out_val_off", bus.out_val, 0);
        @(posedge clk);
        #1;

        // Same line with a stalling sink.
        rand_rdy = 1'b1;
        push_str("   3: ab\n");
        send("a", 1'b0, 1'b0);
        send("b", 1'b1, 1'b0);
        wait_idle();
        rand_rdy = 1'b0;

        // Overflow at NCHARS=4 and its stickiness across the next line.
        pulses(9);
        push_str("  12: ABCD\n");
        send_str("ABCDEF");
        wait_idle();
        check("overflow_set", bus.overflow, 1);
        push_str("  12: Q\n");
        send("Q", 1'b1, 1'b0);
        wait_idle();
        check("overflow_sticky", bus.overflow, 1);

        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();

        // Wrap 9999 -> 0000; same-cycle cycle_inc must not reach the prefix.
        pulses(10000);
        push_str("   0: x\n");
        send("x", 1'b1, 1'b1);
        wait_idle();

        // Count now 1 + 1233 = 1234; a lone null with in_last gives an empty body.
        pulses(1233);
        push_str("1234: \n");
        send(8'h00, 1'b1, 1'b0);
        wait_idle();

        // Asynchronous reset in the middle of the body.
        push_str("1234: uvwx\n");
        send_str("uvwxyz");
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_out_val", bus.out_val, 0);
        check("async_in_rdy",  bus.in_rdy,  0);
        check("async_busy",    bus.busy,    0);
        check("async_ovf",     bus.overflow, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        push_str("   0: z\n");
        send("z", 1'b1, 1'b0);
        wait_idle();
        check("overflow_clear", bus.overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
